// File: rtl/shift_arbiter_pkg.sv
// Shared types and constants for the two-requester shifter front end.
package shift_arbiter_pkg;

    // Width of the shared shifter datapath
    localparam int SHIFT_W = 8;

    // Control FSM encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Command field encodings
    localparam logic DIR_LEFT   = 1'b0;
    localparam logic DIR_RIGHT  = 1'b1;
    localparam logic TYPE_ARITH = 1'b0;
    localparam logic TYPE_LOGIC = 1'b1;

    // Requester identifiers
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response channels and debug outputs of shift_arbiter.
// master = requester side, slave = the arbiter itself.
interface shift_arbiter_if #(
    parameter int CNT_W = 8
);
    import shift_arbiter_pkg::*;

    logic               req0_valid;
    logic               req0_ready;
    logic [SHIFT_W-1:0] req0_din;
    logic [2:0]         req0_shamt;
    logic               req0_dir;
    logic               req0_type;

    logic               req1_valid;
    logic               req1_ready;
    logic [SHIFT_W-1:0] req1_din;
    logic [2:0]         req1_shamt;
    logic               req1_dir;
    logic               req1_type;

    logic               rsp0_valid;
    logic               rsp0_ready;
    logic               rsp1_valid;
    logic               rsp1_ready;
    logic [SHIFT_W-1:0] rsp_dout;

    logic               busy;
    logic [CNT_W-1:0]   grant_cnt0;
    logic [CNT_W-1:0]   grant_cnt1;

    modport master (
        output req0_valid, req0_din, req0_shamt, req0_dir, req0_type,
        output req1_valid, req1_din, req1_shamt, req1_dir, req1_type,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_dout,
        input  busy, grant_cnt0, grant_cnt1
    );

    modport slave (
        input  req0_valid, req0_din, req0_shamt, req0_dir, req0_type,
        input  req1_valid, req1_din, req1_shamt, req1_dir, req1_type,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_dout,
        output busy, grant_cnt0, grant_cnt1
    );

endinterface

// File: rtl/shift_arbiter_barrel_shift8.sv
// Three-stage mux-based 8-bit combinational barrel shifter.
// Right shifts fill with din[7] for arithmetic and zero for logical;
// left shifts always fill with zero.
module barrel_shift8
    import shift_arbiter_pkg::*;
(
    input  logic [7:0] din_i,
    input  logic [2:0] shamt_i,
    input  logic       dir_i,
    input  logic       type_i,
    output logic [7:0] dout_o
);

    logic       fill;
    logic [7:0] stage1;
    logic [7:0] stage2;
    logic [7:0] stage4;

    // Shift by 1, 2 then 4 positions, each stage selected by one shamt bit
    always_comb begin
        fill = (dir_i == DIR_RIGHT && type_i == TYPE_ARITH) ? din_i[7] : 1'b0;

        stage1 = din_i;
        if (shamt_i[0]) begin
            stage1 = (dir_i == DIR_RIGHT) ? {fill, din_i[7:1]} : {din_i[6:0], 1'b0};
        end

        stage2 = stage1;
        if (shamt_i[1]) begin
            stage2 = (dir_i == DIR_RIGHT) ? {{2{fill}}, stage1[7:2]} : {stage1[5:0], 2'b00};
        end

        stage4 = stage2;
        if (shamt_i[2]) begin
            stage4 = (dir_i == DIR_RIGHT) ? {{4{fill}}, stage2[7:4]} : {stage2[3:0], 4'b0000};
        end

        dout_o = stage4;
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin front end sharing one barrel shifter between two requesters.
// Accept in IDLE, compute in EXEC, hold the registered result in RESP
// until the owner takes it. Per-requester saturating grant counters.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_arbiter_if.slave bus
);

    if (DATA_W != SHIFT_W) begin : g_bad_width
        $error("shift_arbiter: DATA_W must be 8 to match barrel_shift8");
    end

    state_t           state_q, state_d;
    logic             last_grant_q;
    logic             owner_q;
    logic [7:0]       din_q;
    logic [2:0]       shamt_q;
    logic             dir_q;
    logic             type_q;
    logic [7:0]       dout_q;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    logic             sel;
    logic             accept;
    logic             handshake;
    logic [7:0]       shift_res;

    barrel_shift8 u_shift (
        .din_i   (din_q),
        .shamt_i (shamt_q),
        .dir_i   (dir_q),
        .type_i  (type_q),
        .dout_o  (shift_res)
    );

    // Pick the requester to serve: a lone valid wins, a tie goes to the one not granted last
    always_comb begin
        sel = REQ0;
        if (bus.req0_valid && bus.req1_valid) begin
            sel = ~last_grant_q;
        end else if (bus.req1_valid) begin
            sel = REQ1;
        end
    end

    // Next-state logic plus the accept and response handshake strobes
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        handshake = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                handshake = (owner_q == REQ1) ? bus.rsp1_ready : bus.rsp0_ready;
                if (handshake) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the winning command, remember the grant and bump the owner's counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= REQ1;
            owner_q      <= REQ0;
            din_q        <= '0;
            shamt_q      <= '0;
            dir_q        <= 1'b0;
            type_q       <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else if (accept) begin
            last_grant_q <= sel;
            owner_q      <= sel;
            if (sel == REQ1) begin
                din_q   <= bus.req1_din;
                shamt_q <= bus.req1_shamt;
                dir_q   <= bus.req1_dir;
                type_q  <= bus.req1_type;
                if (cnt1_q != {CNT_W{1'b1}}) begin
                    cnt1_q <= cnt1_q + 1'b1;
                end
            end else begin
                din_q   <= bus.req0_din;
                shamt_q <= bus.req0_shamt;
                dir_q   <= bus.req0_dir;
                type_q  <= bus.req0_type;
                if (cnt0_q != {CNT_W{1'b1}}) begin
                    cnt0_q <= cnt0_q + 1'b1;
                end
            end
        end
    end

    // Register the shifter result at the end of EXEC; it stays put through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (state_q == EXEC) begin
            dout_q <= shift_res;
        end
    end

    assign bus.req0_ready = rst_n && accept && (sel == REQ0);
    assign bus.req1_ready = rst_n && accept && (sel == REQ1);
    assign bus.rsp0_valid = (state_q == RESP) && (owner_q == REQ0);
    assign bus.rsp1_valid = (state_q == RESP) && (owner_q == REQ1);
    assign bus.rsp_dout   = dout_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.grant_cnt0 = cnt0_q;
    assign bus.grant_cnt1 = cnt1_q;

endmodule
